// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared defaults and read-FSM state type for the memory FIFO controller
package mem_pkg;

  localparam int DEF_MEM_DEPTH  = 16;
  localparam int DEF_MEM_WIDTH  = 8;
  localparam int DEF_ADD_WIDTH  = 4;
  localparam int DEF_RD_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    HOLD    = 2'd2
  } rd_state_e;

endpackage

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller owning the write/read pointers of an external dual-port memory
module mem_fifo_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MEM_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MEM_WIDTH-1:0] out_data,
  output logic                 mem_valid,
  output logic                 mem_wr_en,
  output logic [ADD_WIDTH-1:0] mem_wr_addr,
  output logic [MEM_WIDTH-1:0] mem_wr_data,
  output logic                 mem_rd_en,
  output logic [ADD_WIDTH-1:0] mem_rd_addr,
  input  logic [MEM_WIDTH-1:0] mem_rdata,
  input  logic                 mem_ready,
  output logic [ADD_WIDTH:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 rd_err
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic [ADD_WIDTH:0] wr_ptr;
  logic [ADD_WIDTH:0] rd_ptr;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timer_next;
  rd_state_e          state;
  rd_state_e          state_next;
  logic               accept;
  logic               issue_rd;
  logic               capture;
  logic               drop;
  logic               pop_done;

  // count reflects entries not yet read-issued; an entry in flight or in out_data is no longer counted
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == (ADD_WIDTH+1)'(MEM_DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full & ~rst;
  assign accept    = in_valid & in_ready;
  assign mem_valid = mem_wr_en | mem_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    issue_rd   = 1'b0;
    capture    = 1'b0;
    drop       = 1'b0;
    pop_done   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          issue_rd   = 1'b1;
          state_next = RD_PEND;
        end
      end
      RD_PEND: begin
        if (mem_ready) begin
          capture    = 1'b1;
          state_next = HOLD;
        end else if (timer == TW'(RD_TIMEOUT - 1)) begin
          drop       = 1'b1;
          state_next = IDLE;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          pop_done = 1'b1;
          if (count != '0) begin
            issue_rd   = 1'b1;
            state_next = RD_PEND;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (issue_rd) timer_next = '0;
  end

  // count is registered-pointer based, so a read can only follow a write by at least one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      rd_err      <= 1'b0;
    end else begin
      mem_wr_en <= accept;
      mem_rd_en <= issue_rd;
      if (accept) begin
        mem_wr_addr <= wr_ptr[ADD_WIDTH-1:0];
        mem_wr_data <= in_data;
        wr_ptr      <= wr_ptr + (ADD_WIDTH+1)'(1);
      end
      if (issue_rd) begin
        mem_rd_addr <= rd_ptr[ADD_WIDTH-1:0];
        rd_ptr      <= rd_ptr + (ADD_WIDTH+1)'(1);
      end
      if (capture) begin
        out_data  <= mem_rdata;
        out_valid <= 1'b1;
      end else if (pop_done) begin
        out_valid <= 1'b0;
      end
      if (drop) rd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - scoreboard bench for mem_fifo_ctrl with a behavioural 16x8 memory
module tb_mem_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       mem_valid;
  logic       mem_wr_en;
  logic [3:0] mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic       mem_rd_en;
  logic [3:0] mem_rd_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       rd_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_pop    = 0;

  logic [7:0] exp_q[$];
  logic [3:0] wr_log[$];
  logic       prev_err = 1'b0;
  logic       mem_stall = 1'b0;
  logic       inject_ready = 1'b0;
  logic [7:0] mem_arr [16];

  always #5 clk = ~clk;

  mem_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .count(count), .full(full), .empty(empty), .rd_err(rd_err)
  );

  // one-cycle-latency memory; mem_stall withholds read responses, inject_ready fakes a stray one
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) mem_arr[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en && !mem_stall) begin
      mem_rdata <= mem_arr[mem_rd_addr];
      mem_ready <= 1'b1;
    end else begin
      mem_ready <= inject_ready;
    end
  end

  // scoreboard: push on accept, drop oldest on a read timeout, compare on pop
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      exp_q.delete();
      prev_err = 1'b0;
    end else begin
      if (mem_wr_en) wr_log.push_back(mem_wr_addr);
      if (rd_err && !prev_err && exp_q.size() > 0) e = exp_q.pop_front();
      prev_err = rd_err;
      if (out_valid && out_ready) begin
        n_checks++;
        n_pop++;
        if (exp_q.size() == 0) begin
          $display("FAIL pop_data: got %02h with no entry expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) $display("FAIL pop_data: got %02h expected %02h", out_data, e);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300 && exp_q.size() > 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: %0d entries left expected 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    n_checks++;
    if ({count, empty, full, out_valid, rd_err} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_status: got cnt=%0d e=%b f=%b ov=%b err=%b expected 0 1 0 0 0",
               count, empty, full, out_valid, rd_err);
    else n_pass++;
    n_checks++;
    if ({mem_valid, mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data, out_data} !== '0)
      $display("FAIL reset_mem_outputs: got v=%b we=%b re=%b wa=%0d ra=%0d wd=%02h od=%02h expected all 0",
               mem_valid, mem_wr_en, mem_rd_en, mem_wr_addr, mem_rd_addr, mem_wr_data, out_data);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %b expected 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_order();
    logic [7:0] vals [3];
    int e_cyc, v_cyc, pop0;
    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    wr_log.delete(); pop0 = n_pop; e_cyc = -1; v_cyc = -1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          in_valid = 1'b1; in_data = vals[i];
          if (i == 0) e_cyc = cyc + 1;
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 20 && v_cyc < 0; k++) begin
          @(negedge clk);
          if (out_valid) v_cyc = cyc;
        end
      end
    join
    n_checks++;
    if (v_cyc - e_cyc != 3) $display("FAIL order_latency: got %0d cycles expected 3", v_cyc - e_cyc);
    else n_pass++;
    drain("order");
    n_checks++;
    if (n_pop - pop0 != 3) $display("FAIL order_pops: got %0d expected 3", n_pop - pop0);
    else n_pass++;
    n_checks++;
    if (wr_log.size() != 3 || wr_log[0] !== 4'd0 || wr_log[1] !== 4'd1 || wr_log[2] !== 4'd2)
      $display("FAIL order_wr_addr: got %0d writes first=%0d expected 3 writes at 0,1,2",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 4'hF);
    else n_pass++;
  endtask

  task automatic test_fill();
    int acc0;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'h10 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (n_acc - acc0 != 17) $display("FAIL fill_accepted: got %0d expected 17", n_acc - acc0);
    else n_pass++;
    n_checks++;
    if ({full, empty, count, in_ready} !== {1'b1, 1'b0, 5'd16, 1'b0})
      $display("FAIL fill_status: got f=%b e=%b cnt=%0d ir=%b expected 1 0 16 0", full, empty, count, in_ready);
    else n_pass++;
    n_checks++;
    if ({out_valid, out_data} !== {1'b1, 8'h10})
      $display("FAIL fill_head: got ov=%b od=%02h expected 1 10", out_valid, out_data);
    else n_pass++;
  endtask

  task automatic test_full_release();
    int pop0;
    wr_log.delete(); pop0 = n_pop;
    @(posedge clk); #1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_ready, full, count, mem_rd_en} !== {1'b1, 1'b0, 5'd15, 1'b1})
      $display("FAIL release_status: got ir=%b f=%b cnt=%0d re=%b expected 1 0 15 1",
               in_ready, full, count, mem_rd_en);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h99;
    tick();
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (wr_log.size() != 1 || wr_log[0] !== 4'd1)
      $display("FAIL release_wr_addr: got %0d writes addr=%0d expected 1 write at 1",
               wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 4'hF);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain("release");
    n_checks++;
    if (n_pop - pop0 != 18) $display("FAIL release_pops: got %0d expected 18", n_pop - pop0);
    else n_pass++;
  endtask

  task automatic test_random_stream();
    int acc0, pop0, bad;
    bit wrapped;
    logic [3:0] nxt;
    wr_log.delete(); acc0 = n_acc; pop0 = n_pop; bad = 0; wrapped = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3000 && (n_acc - acc0) < 40; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain("stream");
    n_checks++;
    if (n_acc - acc0 != 40 || n_pop - pop0 != 40)
      $display("FAIL stream_counts: got acc=%0d pop=%0d expected 40 40", n_acc - acc0, n_pop - pop0);
    else n_pass++;
    for (int i = 1; i < wr_log.size(); i++) begin
      nxt = wr_log[i-1] + 4'd1;
      if (wr_log[i] !== nxt) bad++;
      if (wr_log[i-1] == 4'd15 && wr_log[i] == 4'd0) wrapped = 1'b1;
    end
    n_checks++;
    if (bad != 0 || !wrapped || wr_log.size() != 40)
      $display("FAIL stream_wr_addr: got %0d gaps wrap=%b writes=%0d expected 0 1 40", bad, wrapped, wr_log.size());
    else n_pass++;
  endtask

  task automatic test_timeout();
    int iss, err, pop0;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; mem_stall = 1'b1; pop0 = n_pop; iss = -1; err = -1;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && iss < 0; k++) begin
      @(negedge clk);
      if (mem_rd_en) iss = cyc;
    end
    for (int k = 0; k < 20 && err < 0 && iss >= 0; k++) begin
      @(negedge clk);
      if (rd_err) err = cyc;
    end
    n_checks++;
    if (iss < 0 || err < 0 || err - iss != 8)
      $display("FAIL timeout_delay: got issue=%0d err=%0d expected err 8 cycles after issue", iss, err);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, mem_rd_en, empty, exp_q.size() == 0} !== 4'b0011)
      $display("FAIL timeout_idle: got ov=%b re=%b e=%b q=%0d expected 0 0 1 0",
               out_valid, mem_rd_en, empty, exp_q.size());
    else n_pass++;
    @(posedge clk); #1;
    mem_stall = 1'b0; in_valid = 1'b1; in_data = 8'h6B;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20 && n_pop == pop0; k++) @(negedge clk);
    n_checks++;
    if (n_pop - pop0 != 1 || rd_err !== 1'b1)
      $display("FAIL timeout_recover: got pops=%0d err=%b expected 1 1", n_pop - pop0, rd_err);
    else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    int iss, bad;
    iss = -1; bad = 0;
    @(posedge clk); #1;
    mem_stall = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && iss < 0; k++) begin
      @(negedge clk);
      if (mem_rd_en) iss = cyc;
    end
    n_checks++;
    if (iss < 0) $display("FAIL inflight_issue: got no read within 10 cycles expected one");
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    rst = 1'b0; inject_ready = 1'b1;
    tick();
    inject_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if ({out_valid, out_data, count, rd_err, mem_wr_en, mem_rd_en, mem_valid} !== '0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL inflight_reset: got %0d cycles with nonzero outputs expected 0", bad);
    else n_pass++;
    mem_stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill();
    test_full_release();
    test_random_stream();
    test_timeout();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
